// File: rtl/axis_sign_splitter_pkg.sv
// Shared definitions for the sign splitter: skid FSM encoding and default widths.
package axis_sign_splitter_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int AXIS_TDATA_WIDTH_DEF = 32;
  localparam int CNTR_WIDTH_DEF       = 32;

endpackage

// File: rtl/axis_skid_slice.sv
// Generic full-throughput skid register slice: registered ready and valid,
// main register plus one skid register so no combinational ready path exists.
module axis_skid_slice
  import axis_sign_splitter_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  skid_state_e   state_r;
  skid_state_e   next_state_s;
  logic          ready_r;
  logic          valid_r;
  logic [DW-1:0] main_r;
  logic [DW-1:0] skid_r;
  logic          accept_s;
  logic          xfer_s;
  logic          load_main_s;
  logic          load_skid_s;
  logic          skid_to_main_s;

  assign accept_s = s_valid & ready_r;
  assign xfer_s   = valid_r & m_ready;

  // State register; ready/valid are registered decodes of the next state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= SKID_EMPTY;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s != SKID_FULL);
      valid_r <= (next_state_s != SKID_EMPTY);
    end
  end

  // Next-state decode from handshake events
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SKID_EMPTY: begin
        if (accept_s) next_state_s = SKID_ONE;
        else          next_state_s = SKID_EMPTY;
      end
      SKID_ONE: begin
        if (accept_s && !xfer_s)      next_state_s = SKID_FULL;
        else if (!accept_s && xfer_s) next_state_s = SKID_EMPTY;
        else                          next_state_s = SKID_ONE;
      end
      SKID_FULL: begin
        if (xfer_s) next_state_s = SKID_ONE;
        else        next_state_s = SKID_FULL;
      end
      default: next_state_s = SKID_EMPTY;
    endcase
  end

  // Data-path load controls per state
  always_comb begin
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    case (state_r)
      SKID_EMPTY: load_main_s = accept_s;
      SKID_ONE: begin
        if (accept_s && xfer_s) load_main_s = 1'b1;
        else if (accept_s)      load_skid_s = 1'b1;
        else                    load_main_s = 1'b0;
      end
      SKID_FULL: skid_to_main_s = xfer_s;
      default: begin
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
      end
    endcase
  end

  // Main and skid data registers; main only changes on a load, so the output holds under stall
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_r <= {DW{1'b0}};
      skid_r <= {DW{1'b0}};
    end else begin
      if (load_main_s)         main_r <= s_data;
      else if (skid_to_main_s) main_r <= skid_r;
      else                     main_r <= main_r;
      if (load_skid_s) skid_r <= s_data;
      else             skid_r <= skid_r;
    end
  end

  assign s_ready = ready_r;
  assign m_valid = valid_r;
  assign m_data  = main_r;

endmodule

// File: rtl/axis_sign_splitter.sv
// Signed-to-sign-magnitude AXI-Stream stage: optional negate, split sign to tuser,
// unsigned magnitude to tdata, with a count of accepted negative beats.
module axis_sign_splitter
  import axis_sign_splitter_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
  parameter int CNTR_WIDTH       = CNTR_WIDTH_DEF
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_flag,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic [CNTR_WIDTH-1:0]       sts_neg_count
);

  localparam int W = AXIS_TDATA_WIDTH;

  logic [W-1:0]          neg_in_s;
  logic [W-1:0]          v_s;
  logic [W-1:0]          mag_s;
  logic                  sign_s;
  logic                  accept_s;
  logic [W:0]            m_data_s;
  logic [CNTR_WIDTH-1:0] cnt_r;

  // Transform at acceptance; the most-negative value maps to 2^(W-1), which fits unsigned W bits
  always_comb begin
    neg_in_s = {W{1'b0}} - s_axis_tdata;
    if (cfg_flag) v_s = neg_in_s;
    else          v_s = s_axis_tdata;
    sign_s = v_s[W-1];
    if (sign_s) mag_s = ~v_s + {{(W-1){1'b0}}, 1'b1};
    else        mag_s = v_s;
  end

  axis_skid_slice #(
    .DW (W + 1)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_data  ({sign_s, mag_s}),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_data_s),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign accept_s     = s_axis_tvalid & s_axis_tready;
  assign m_axis_tuser = m_data_s[W];
  assign m_axis_tdata = m_data_s[W-1:0];

  // Negative-beat counter, wraps silently
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= {CNTR_WIDTH{1'b0}};
    end else if (accept_s && sign_s) begin
      cnt_r <= cnt_r + {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sts_neg_count = cnt_r;

endmodule

// File: tb/tb_axis_sign_splitter.sv
// Bench for axis_sign_splitter (W=16): vector table, backpressure and reset sequences,
// random handshake run with a scoreboard; a second DUT with a 4-bit counter shows wrap.
module tb_axis_sign_splitter;

  localparam int W = 16;

  logic         aclk     = 1'b0;
  logic         aresetn  = 1'b0;
  logic         cfg_flag = 1'b0;
  logic         s_tvalid = 1'b0;
  logic [W-1:0] s_tdata  = '0;
  logic         m_tready = 1'b0;
  logic         s_tready, m_tuser, m_tvalid;
  logic [W-1:0] m_tdata;
  logic [31:0]  cnt;
  logic         s_tready4, m_tuser4, m_tvalid4;
  logic [W-1:0] m_tdata4;
  logic [3:0]   cnt4;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axis_sign_splitter #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(32)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_flag(cfg_flag),
    .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .sts_neg_count(cnt));

  axis_sign_splitter #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(4)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .cfg_flag(cfg_flag),
    .s_axis_tready(s_tready4), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata4), .m_axis_tuser(m_tuser4),
    .m_axis_tvalid(m_tvalid4), .sts_neg_count(cnt4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_split(input logic [W-1:0] d, input logic c);
    logic [W-1:0] v;
    logic [W-1:0] m;
    v = c ? W'(16'd0 - d) : d;
    m = v[W-1] ? W'(16'd0 - v) : v;
    return {v[W-1], m};
  endfunction

  // Scoreboard and invariant monitor, sampled on the falling edge
  logic [W:0] exp_q[$];
  int         model_cnt  = 0;
  logic       prev_stall = 1'b0;
  logic [W:0] prev_out   = '0;

  always @(negedge aclk) begin
    logic [W:0] e;
    if (!aresetn) begin
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      chk("neg_count", cnt, 32'(model_cnt));
      chk("neg_count_w4", 32'(cnt4), 32'(model_cnt & 15));
      chk("w4_handshake", 32'({s_tready4, m_tvalid4}), 32'({s_tready, m_tvalid}));
      chk("w4_data", 32'({m_tuser4, m_tdata4}), 32'({m_tuser, m_tdata}));
      if (prev_stall) begin
        chk("stall_valid", 32'(m_tvalid), 32'd1);
        chk("stall_data", 32'({m_tuser, m_tdata}), 32'(prev_out));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_beat", 32'({m_tuser, m_tdata}), 32'(e));
        end
      end
      if (s_tvalid && s_tready) begin
        e = ref_split(s_tdata, cfg_flag);
        exp_q.push_back(e);
        if (e[W]) model_cnt++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tuser, m_tdata};
    end
  end

  typedef struct {
    logic [W-1:0] din;
    logic         cfg;
    logic [W-1:0] mag;
    logic         sign;
    int           cnt;
  } vec_t;

  vec_t tbl[14];

  // One cycle of held-until-accepted streaming; returns whether the beat went in
  task automatic step(output logic acc);
    @(negedge aclk);
    acc = s_tvalid && s_tready;
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_sample();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   k;
    int   sent;
    int   cyc;
    logic [W:0] held;

    tbl[0]  = '{16'h0005, 1'b0, 16'h0005, 1'b0, 0};
    tbl[1]  = '{16'hFFFB, 1'b0, 16'h0005, 1'b1, 1};
    tbl[2]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1};
    tbl[3]  = '{16'h8000, 1'b0, 16'h8000, 1'b1, 2};
    tbl[4]  = '{16'h8000, 1'b1, 16'h8000, 1'b1, 3};
    tbl[5]  = '{16'h0007, 1'b1, 16'h0007, 1'b1, 4};
    tbl[6]  = '{16'h0003, 1'b1, 16'h0003, 1'b1, 5};
    tbl[7]  = '{16'h0003, 1'b0, 16'h0003, 1'b0, 5};
    tbl[8]  = '{16'h0003, 1'b1, 16'h0003, 1'b1, 6};
    tbl[9]  = '{16'h0003, 1'b0, 16'h0003, 1'b0, 6};
    tbl[10] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 6};
    tbl[11] = '{16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 6};
    tbl[12] = '{16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 7};
    tbl[13] = '{16'h8001, 1'b1, 16'h7FFF, 1'b0, 7};

    #20;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_m_tuser", 32'(m_tuser), 32'd0);
    chk("rst_count", cnt, 32'd0);
    #2 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("ready_after_release", 32'(s_tready), 32'd1);
    chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);

    // Back-to-back vectors: each output appears one cycle after acceptance
    m_tready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s_tdata  = tbl[i].din;
      cfg_flag = tbl[i].cfg;
      s_tvalid = 1'b1;
      @(posedge aclk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(m_tvalid), 32'd1);
      chk($sformatf("vec%0d_mag", i), 32'(m_tdata), 32'(tbl[i].mag));
      chk($sformatf("vec%0d_sign", i), 32'(m_tuser), 32'(tbl[i].sign));
      chk($sformatf("vec%0d_count", i), cnt, 32'(tbl[i].cnt));
    end
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    chk("empty_after_stream", 32'(m_tvalid), 32'd0);

    // Backpressure: three stall cycles under continuous valid input
    k = 0;
    s_tdata  = 16'h0100;
    cfg_flag = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      if (acc) begin k++; s_tdata = W'(16'h0100 + k); cfg_flag = k[0]; end
    end
    m_tready = 1'b0;
    held = {m_tuser, m_tdata};
    step(acc);
    if (acc) begin k++; s_tdata = W'(16'h0100 + k); cfg_flag = k[0]; end
    chk("bp_ready_low", 32'(s_tready), 32'd0);
    step(acc);
    chk("bp_no_accept", 32'(acc), 32'd0);
    step(acc);
    chk("bp_ready_still_low", 32'(s_tready), 32'd0);
    chk("bp_hold_data", 32'({m_tuser, m_tdata}), 32'(held));
    m_tready = 1'b1;
    step(acc);
    chk("bp_ready_back", 32'(s_tready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(acc);
      if (acc) begin k++; s_tdata = W'(16'h0100 + k); cfg_flag = k[0]; end
    end
    drain();

    // Random valid/ready with scoreboard
    sent = 0;
    cyc  = 0;
    s_tvalid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      step(acc);
      cyc++;
      if (acc) sent++;
      if (acc || !s_tvalid) begin
        s_tvalid = ($urandom_range(0, 99) < 70);
        s_tdata  = rand_sample();
      end
      cfg_flag = 1'($urandom_range(0, 1));
      m_tready = ($urandom_range(0, 99) < 60);
    end
    chk("random_beats_sent", 32'(sent), 32'd10000);
    drain();

    // Counter wrap: 17 negatives after a fresh reset
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #10 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    s_tdata  = 16'hFFFF;
    cfg_flag = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    chk("wrap_count32", cnt, 32'd17);
    chk("wrap_count4", 32'(cnt4), 32'd1);
    drain();

    // Reset asserted while FULL
    m_tready = 1'b0;
    s_tdata  = 16'h0AAA;
    s_tvalid = 1'b1;
    k = 0;
    while (s_tready && k < 10) begin
      step(acc);
      k++;
    end
    chk("reached_full", 32'(s_tready), 32'd0);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("async_rst_tready", 32'(s_tready), 32'd0);
    s_tdata  = 16'hFFF0;
    cfg_flag = 1'b0;
    m_tready = 1'b1;
    #15 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_count", cnt, 32'd0);
    chk("post_rst_no_output", 32'(m_tvalid), 32'd0);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    chk("post_rst_first_valid", 32'(m_tvalid), 32'd1);
    chk("post_rst_first_data", 32'({m_tuser, m_tdata}), 32'({1'b1, 16'h0010}));
    chk("post_rst_count_one", cnt, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_sign_splitter.md
Name: axis_sign_splitter

Overview:
- Registered AXI-Stream stage that converts signed samples to sign-magnitude form.
- Inverse-side companion to the conditional negator: recovers the sign as a side-band bit (m_axis_tuser) and outputs an unsigned magnitude.
- Full-throughput skid-buffered handshake, so s_axis_tready is registered and there is no combinational ready path.
- Sits after DSP chains that feed sign-aware consumers (log/magnitude detectors, histogrammers); a negative-sample counter is exposed for status registers.

Parameters:
- AXIS_TDATA_WIDTH, 32, sample width W in bits (signed in, unsigned out); legal range 2..64.
- CNTR_WIDTH, 32, width of the negative-sample counter.

Ports:
- aclk  input  1  system clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- cfg_flag  input  1  1 = negate sample before splitting; sampled per accepted beat.
- s_axis_tready  output  1  registered ready.
- s_axis_tdata  input  W  signed two's-complement sample.
- s_axis_tvalid  input  1  input valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tdata  output  W  unsigned magnitude.
- m_axis_tuser  output  1  sign bit, 1 = negative.
- m_axis_tvalid  output  1  output valid.
- sts_neg_count  output  CNTR_WIDTH  number of accepted beats with sign = 1.

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid = 0, s_axis_tready = 0, m_axis_tdata = 0, m_axis_tuser = 0, sts_neg_count = 0, skid buffer empty.
  - s_axis_tready rises on the first aclk edge after release.
  - Reset mid-transfer discards held beats; no beat is emitted twice.
- Transfers: input accepted when s_axis_tvalid & s_axis_tready; output completes when m_axis_tvalid & m_axis_tready.
- Transform, applied at acceptance:
  - v = cfg_flag ? -v_in : v_in, computed modulo 2^W.
  - sign = v[W-1].
  - magnitude = sign ? (~v + 1) : v, as a W-bit unsigned value.
- Width rules:
  - Most-negative input -2^(W-1) gives sign = 1, magnitude = 2^(W-1). This is exact in W unsigned bits, so no saturation.
  - With cfg_flag = 1 the same input negates to itself (wrap), so sign = 1 and magnitude = 2^(W-1).
  - Zero gives sign 0, magnitude 0, including -0.
- cfg_flag may change on any cycle. Only the value present at each beat's acceptance applies to that beat; beats already held are unaffected.
- Latency: 1 cycle from acceptance to m_axis_tvalid when the stage is empty.
- Throughput: 1 beat/cycle while m_axis_tready stays high.
- Skid buffer FSM, states EMPTY, ONE, FULL:
  - EMPTY: output invalid, ready = 1. Accept → ONE.
  - ONE: main register valid, ready = 1.
    - Accept with no output transfer → FULL; incoming beat goes to skid register, ready drops to 0 next cycle.
    - Accept with output transfer → stay in ONE; main register loads the new beat.
    - Output transfer with no accept → EMPTY.
  - FULL: ready = 0. Output transfer → ONE; skid moves to main, ready = 1 next cycle.
- Ordering is strictly preserved. No beat is dropped or duplicated under any tvalid/tready pattern.
- Output stability: m_axis_tdata and m_axis_tuser stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Counter:
  - sts_neg_count increments by 1 on each accepted beat with sign = 1, registered, visible 1 cycle after acceptance.
  - Wraps from 2^CNTR_WIDTH-1 to 0 with no flag.
  - Simultaneous accept and output transfer does not affect counting.

Decomposition:
- Shared package holds:
  - skid state encoding (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2);
  - default widths AXIS_TDATA_WIDTH_DEF = 32, CNTR_WIDTH_DEF = 32.
- One natural sub-module: axis_skid_slice, a generic W+1-bit skid register implementing the FSM above.
- The top level holds the transform logic and the counter.

Test Plan (W = 16):
- Reset then stream 0x0005, 0xFFFB, 0x0000 with cfg_flag = 0 and m_axis_tready = 1 → outputs (mag, sign) = (5,0), (5,1), (0,0), each 1 cycle after acceptance; sts_neg_count = 1.
- Input 0x8000 with cfg_flag = 0 and again with cfg_flag = 1 → both give mag 0x8000, sign 1; count += 2.
- cfg_flag = 1 with input 0x0007 → mag 7, sign 1. cfg_flag toggled every cycle over 0x0003 ×4 → signs 1, 0, 1, 0.
- Backpressure: continuous valid input, m_axis_tready low for 3 cycles → s_axis_tready low from the 2nd cycle after stall starts; after release, all beats emerge in order with no loss or duplication and output stable during the stall.
- Random tvalid/tready (≥10k beats, scoreboard) → 100% in-order match; sts_neg_count equals reference count. Preload CNTR_WIDTH = 4 and send 17 negatives → count wraps to 1.
- Assert aresetn low while in FULL → tvalid and ready drop immediately (async); after release, the first output is the first post-reset beat and the count restarts at 0.
